// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, ALU codes,
// datapath mux selects and the controller state type.
package mips_ctrl_pkg;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] J      = 6'h02;
    localparam logic [5:0] JAL    = 6'h03;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] ANDI   = 6'h0c;
    localparam logic [5:0] ORI    = 6'h0d;
    localparam logic [5:0] LUI    = 6'h0f;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2b;

    localparam logic [3:0] ALU_RTYPE = 4'd0;
    localparam logic [3:0] ALU_ADD   = 4'd1;
    localparam logic [3:0] ALU_OR    = 4'd2;
    localparam logic [3:0] ALU_LUI   = 4'd3;
    localparam logic [3:0] ALU_AND   = 4'd4;
    localparam logic [3:0] ALU_SUBEQ = 4'd5;
    localparam logic [3:0] ALU_SUBNE = 4'd6;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_ALU_WB, ST_MEM_ADDR,
        ST_MEM_READ, ST_MEM_WB, ST_MEM_WRITE, ST_BRANCH, ST_JUMP, ST_JAL, ST_TRAP
    } stateT;

    // States that hold a memory access open until mem_ready.
    function automatic logic isWaitState(input stateT s);
        return s inside {ST_FETCH, ST_MEM_READ, ST_MEM_WRITE};
    endfunction

    function automatic logic [3:0] iTypeAluCode(input logic [5:0] opcode);
        case (opcode)
            ORI:     return ALU_OR;
            LUI:     return ALU_LUI;
            ANDI:    return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on memory; flags the cycle on which
// the wait would reach MEM_TIMEOUT.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic waiting,
    output logic timeout
);

    logic [7:0] waitCount;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            waitCount <= '0;
        end else if (clear) begin
            waitCount <= '0;
        end else if (waiting) begin
            waitCount <= waitCount + 8'd1;
        end
    end

    assign timeout = waiting && (waitCount == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory handshake stall and trap states.
// Optional MULTICYCLE_JAL_EN adds the JAL state and the link output.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_eq,
    output logic               pc_write_ne,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_source,
    output logic [ALUOP_W-1:0] alu_op,
`ifdef MULTICYCLE_JAL_EN
    output logic               link,
`endif
    output logic               illegal_op,
    output logic               bus_error
);

    stateT      state, stateNext;
    logic       regDstQ, regDstNext;
    logic       illegalQ, busErrQ;
    logic       setIllegal, setBusErr;
    logic [3:0] aluCode;
    logic       memWaiting, timeout;

    assign memWaiting = isWaitState(state) && !mem_ready;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) uTimer (
        .clk     (clk),
        .reset   (reset),
        .clear   (stateNext != state),
        .waiting (memWaiting),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_FETCH;
            regDstQ  <= 1'b0;
            illegalQ <= 1'b0;
            busErrQ  <= 1'b0;
        end else begin
            state    <= stateNext;
            regDstQ  <= regDstNext;
            illegalQ <= illegalQ | setIllegal;
            busErrQ  <= busErrQ | setBusErr;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        stateNext   = state;
        regDstNext  = regDstQ;
        setIllegal  = 1'b0;
        setBusErr   = 1'b0;
        pc_write    = 1'b0;
        pc_write_eq = 1'b0;
        pc_write_ne = 1'b0;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_RT;
        pc_source   = PCSRC_ALU;
        aluCode     = ALU_RTYPE;
`ifdef MULTICYCLE_JAL_EN
        link        = 1'b0;
`endif
        // Holding reset low silences every strobe, whatever the state register holds.
        if (reset) begin
            case (state)
                ST_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        alu_src_b = SRCB_FOUR;
                        aluCode   = ALU_ADD;
                        stateNext = ST_DECODE;
                    end else if (timeout) begin
                        stateNext = ST_TRAP;
                        setBusErr = 1'b1;
                    end
                end
                ST_DECODE: begin
                    alu_src_b = SRCB_IMM_SH2;
                    aluCode   = ALU_ADD;
                    case (op)
                        R_TYPE:                stateNext = ST_EXEC_R;
                        ADDI, ORI, LUI, ANDI:  stateNext = ST_EXEC_I;
                        LW, SW:                stateNext = ST_MEM_ADDR;
                        BEQ, BNE:              stateNext = ST_BRANCH;
                        J:                     stateNext = ST_JUMP;
`ifdef MULTICYCLE_JAL_EN
                        JAL:                   stateNext = ST_JAL;
`else
                        JAL: begin
                            stateNext  = ST_TRAP;
                            setIllegal = 1'b1;
                        end
`endif
                        default: begin
                            stateNext  = ST_TRAP;
                            setIllegal = 1'b1;
                        end
                    endcase
                end
                ST_EXEC_R: begin
                    alu_src_a  = 1'b1;
                    regDstNext = 1'b1;
                    stateNext  = ST_ALU_WB;
                end
                ST_EXEC_I: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_IMM;
                    aluCode    = iTypeAluCode(op);
                    regDstNext = 1'b0;
                    stateNext  = ST_ALU_WB;
                end
                ST_ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = regDstQ;
                    stateNext = ST_FETCH;
                end
                ST_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    aluCode   = ALU_ADD;
                    stateNext = (op == SW) ? ST_MEM_WRITE : ST_MEM_READ;
                end
                ST_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) begin
                        stateNext = ST_MEM_WB;
                    end else if (timeout) begin
                        stateNext = ST_TRAP;
                        setBusErr = 1'b1;
                    end
                end
                ST_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    stateNext  = ST_FETCH;
                end
                ST_MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem_ready) begin
                        stateNext = ST_FETCH;
                    end else if (timeout) begin
                        stateNext = ST_TRAP;
                        setBusErr = 1'b1;
                    end
                end
                ST_BRANCH: begin
                    alu_src_a = 1'b1;
                    pc_source = PCSRC_ALUOUT;
                    if (op == BNE) begin
                        aluCode     = ALU_SUBNE;
                        pc_write_ne = 1'b1;
                    end else begin
                        aluCode     = ALU_SUBEQ;
                        pc_write_eq = 1'b1;
                    end
                    stateNext = ST_FETCH;
                end
                ST_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                    stateNext = ST_FETCH;
                end
`ifdef MULTICYCLE_JAL_EN
                ST_JAL: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                    reg_write = 1'b1;
                    link      = 1'b1;
                    stateNext = ST_FETCH;
                end
`endif
                ST_TRAP:  stateNext = ST_TRAP;
                default:  stateNext = ST_TRAP;
            endcase
        end
    end

    assign alu_op     = ALUOP_W'(aluCode);
    assign illegal_op = reset & illegalQ;
    assign bus_error  = reset & busErrQ;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected outputs are queued
// by the stimulus and compared by an independent monitor on the falling edge.
module tb_multicycle_control;

    typedef struct packed {
        logic       pcW, pcEq, pcNe, iod, mr, mw, irW, m2r, rd, rw, sa;
        logic [1:0] sb;
        logic [1:0] ps;
        logic [3:0] aop;
        logic       ill, berr, lnk;
    } outsT;

    localparam outsT O_ZERO   = '0;
    localparam outsT O_FWAIT  = '{mr: 1'b1, default: '0};
    localparam outsT O_FGO    = '{mr: 1'b1, irW: 1'b1, pcW: 1'b1, sb: 2'b01, aop: 4'd1, default: '0};
    localparam outsT O_DEC    = '{sb: 2'b11, aop: 4'd1, default: '0};
    localparam outsT O_EXR    = '{sa: 1'b1, default: '0};
    localparam outsT O_EXI    = '{sa: 1'b1, sb: 2'b10, default: '0};
    localparam outsT O_WBR    = '{rw: 1'b1, rd: 1'b1, default: '0};
    localparam outsT O_WBI    = '{rw: 1'b1, default: '0};
    localparam outsT O_MADDR  = '{sa: 1'b1, sb: 2'b10, aop: 4'd1, default: '0};
    localparam outsT O_MREAD  = '{mr: 1'b1, iod: 1'b1, default: '0};
    localparam outsT O_MWB    = '{rw: 1'b1, m2r: 1'b1, default: '0};
    localparam outsT O_MWRITE = '{mw: 1'b1, iod: 1'b1, default: '0};
    localparam outsT O_BNE    = '{sa: 1'b1, ps: 2'b01, aop: 4'd6, pcNe: 1'b1, default: '0};
    localparam outsT O_BEQ    = '{sa: 1'b1, ps: 2'b01, aop: 4'd5, pcEq: 1'b1, default: '0};
    localparam outsT O_JUMP   = '{pcW: 1'b1, ps: 2'b10, default: '0};
    localparam outsT O_JAL    = '{pcW: 1'b1, ps: 2'b10, rw: 1'b1, lnk: 1'b1, default: '0};
    localparam outsT O_ILL    = '{ill: 1'b1, default: '0};
    localparam outsT O_BERR   = '{berr: 1'b1, default: '0};

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_op;
    logic       illegal_op, bus_error, linkObs;
    outsT       act;

    int checks   = 0;
    int failures = 0;
    outsT  expQ[$];
    string nameQ[$];

    always #5 clk = ~clk;

    multicycle_control #(.ALUOP_W(4), .MEM_TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .pc_write_eq (pc_write_eq),
        .pc_write_ne (pc_write_ne),
        .i_or_d      (i_or_d),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .mem_to_reg  (mem_to_reg),
        .reg_dst     (reg_dst),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_source   (pc_source),
        .alu_op      (alu_op),
`ifdef MULTICYCLE_JAL_EN
        .link        (linkObs),
`endif
        .illegal_op  (illegal_op),
        .bus_error   (bus_error)
    );

`ifndef MULTICYCLE_JAL_EN
    assign linkObs = 1'b0;
`endif

    assign act = {pc_write, pc_write_eq, pc_write_ne, i_or_d, mem_read, mem_write,
                  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                  alu_src_b, pc_source, alu_op, illegal_op, bus_error, linkObs};

    task automatic check(input string name, input outsT got, input outsT want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // One call per clock: drive this cycle's inputs and queue the outputs they should produce.
    task automatic step(input logic rstV, input logic [5:0] opV, input logic rdyV,
                        input outsT want, input string name);
        @(posedge clk);
        #1;
        reset     = rstV;
        op        = opV;
        mem_ready = rdyV;
        expQ.push_back(want);
        nameQ.push_back(name);
    endtask

    task automatic run(input logic [5:0] opV, input logic rdyV, input outsT want, input string name);
        step(1'b1, opV, rdyV, want, name);
    endtask

    // Monitor: compares whatever the DUT presents against the oldest queued expectation.
    initial begin
        outsT  monExp;
        string monName;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                monExp  = expQ.pop_front();
                monName = nameQ.pop_front();
                check(monName, act, monExp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] iOps [4];
        logic [3:0] iAlu [4];
        outsT       e;
        iOps = '{6'h08, 6'h0d, 6'h0f, 6'h0c};
        iAlu = '{4'd1, 4'd2, 4'd3, 4'd4};

        reset = 1'b0; op = 6'h00; mem_ready = 1'b0;

        step(1'b0, 6'h00, 1'b1, O_ZERO, "reset0");
        step(1'b0, 6'h00, 1'b1, O_ZERO, "reset1");

        // R-type: four cycles back to FETCH
        run(6'h00, 1'b1, O_FGO, "r_fetch");
        run(6'h00, 1'b1, O_DEC, "r_decode");
        run(6'h00, 1'b1, O_EXR, "r_exec");
        run(6'h00, 1'b1, O_WBR, "r_wb");

        // LW with three stalled read cycles
        run(6'h23, 1'b1, O_FGO, "lw_fetch");
        run(6'h23, 1'b1, O_DEC, "lw_decode");
        run(6'h23, 1'b1, O_MADDR, "lw_addr");
        for (int i = 0; i < 3; i++) run(6'h23, 1'b0, O_MREAD, "lw_read_stall");
        run(6'h23, 1'b1, O_MREAD, "lw_read_done");
        run(6'h23, 1'b1, O_MWB, "lw_wb");

        run(6'h05, 1'b1, O_FGO, "bne_fetch");
        run(6'h05, 1'b1, O_DEC, "bne_decode");
        run(6'h05, 1'b1, O_BNE, "bne_branch");
        run(6'h04, 1'b1, O_FGO, "beq_fetch");
        run(6'h04, 1'b1, O_DEC, "beq_decode");
        run(6'h04, 1'b1, O_BEQ, "beq_branch");

        run(6'h2b, 1'b1, O_FGO, "sw_fetch");
        run(6'h2b, 1'b1, O_DEC, "sw_decode");
        run(6'h2b, 1'b1, O_MADDR, "sw_addr");
        run(6'h2b, 1'b0, O_MWRITE, "sw_write_stall");
        run(6'h2b, 1'b1, O_MWRITE, "sw_write_done");

        for (int k = 0; k < 4; k++) begin
            e     = O_EXI;
            e.aop = iAlu[k];
            run(iOps[k], 1'b1, O_FGO, "i_fetch");
            run(iOps[k], 1'b1, O_DEC, "i_decode");
            run(iOps[k], 1'b1, e, "i_exec");
            run(iOps[k], 1'b1, O_WBI, "i_wb");
        end

        run(6'h02, 1'b1, O_FGO, "j_fetch");
        run(6'h02, 1'b1, O_DEC, "j_decode");
        run(6'h02, 1'b1, O_JUMP, "j_jump");

        // Illegal opcode: trap is sticky regardless of inputs
        run(6'h3f, 1'b1, O_FGO, "ill_fetch");
        run(6'h3f, 1'b1, O_DEC, "ill_decode");
        for (int i = 0; i < 20; i++) run(6'(i), 1'(i), O_ILL, "ill_trap");
        step(1'b0, 6'h00, 1'b0, O_ZERO, "ill_reset");

        // Fetch timeout: the 15th consecutive waiting cycle traps
        for (int i = 0; i < 15; i++) run(6'h00, 1'b0, O_FWAIT, "to_wait");
        for (int i = 0; i < 3; i++) run(6'h00, 1'b0, O_BERR, "to_trap");
        step(1'b0, 6'h00, 1'b0, O_ZERO, "to_reset");

        // mem_ready arriving on cycle 15 completes normally
        for (int i = 0; i < 14; i++) run(6'h00, 1'b0, O_FWAIT, "edge_wait");
        run(6'h00, 1'b1, O_FGO, "edge_fetch");
        run(6'h00, 1'b1, O_DEC, "edge_decode");
        run(6'h00, 1'b1, O_EXR, "edge_exec");
        // Reset mid-instruction abandons the writeback
        step(1'b0, 6'h00, 1'b1, O_ZERO, "mid_reset");
        run(6'h03, 1'b1, O_FGO, "jal_fetch");
        run(6'h03, 1'b1, O_DEC, "jal_decode");
`ifdef MULTICYCLE_JAL_EN
        run(6'h03, 1'b1, O_JAL, "jal_link");
        run(6'h00, 1'b1, O_FGO, "jal_refetch");
`else
        run(6'h03, 1'b1, O_ILL, "jal_illegal");
        run(6'h00, 1'b1, O_ILL, "jal_illegal_hold");
`endif

        repeat (3) @(posedge clk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations unconsumed, required 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle successor to the single-cycle opcode decoder. A state-machine control unit for the shared-memory MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Stalls on a memory-ready handshake.
- Traps on illegal opcodes or memory timeout.
- Sits between the instruction register and the multicycle datapath muxes and enables.

Parameters:
ALUOP_W, 4, width of the alu_op output; must be >=4.
MEM_TIMEOUT, 15, maximum consecutive cycles waiting on mem_ready before a bus error; range 1..255.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
op  in  6  opcode, IR[31:26]
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_eq  out  1  PC load if ALU zero
pc_write_ne  out  1  PC load if ALU not zero
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
mem_to_reg  out  1  writeback select: 1=MDR
reg_dst  out  1  destination select: 1=rd
reg_write  out  1  register file write
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  00=rt, 01=const 4, 10=sign-extended imm, 11=imm<<2
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
alu_op  out  ALUOP_W  ALU function code
illegal_op  out  1  sticky: unknown opcode trapped
bus_error  out  1  sticky: memory timeout trapped

Behaviour:
- Single clock domain.
- Reset is synchronous and active-low. While reset==0 at a clk edge:
  - state<=FETCH, wait counter<=0, illegal_op<=0, bus_error<=0.
  - During reset all outputs are 0.
- Outputs are a combinational decode of state, plus mem_ready qualification in the wait states. No registered outputs.
- Unlisted outputs are 0 in every state.
- ALU codes: ADD=1, OR=2, LUI=3, AND=4, SUBEQ=5, SUBNE=6, R-type=0. Codes are zero-extended to ALUOP_W.
- States and transitions:
  - FETCH: mem_read=1, i_or_d=0.
    - If mem_ready: ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00; go to DECODE.
    - Else stay.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into ALUOut). Next state by op:
    - 0 -> EXEC_R
    - 8/d/f/c -> EXEC_I
    - 23/2b -> MEM_ADDR
    - 4/5 -> BRANCH
    - 2 -> JUMP
    - other -> TRAP with illegal_op<=1
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=0; go to ALU_WB with reg_dst=1.
  - EXEC_I: alu_src_a=1, alu_src_b=10, alu_op per opcode (ADDI=ADD, ORI=OR, LUI=LUI, ANDI=AND); go to ALU_WB with reg_dst=0.
  - ALU_WB: reg_write=1, mem_to_reg=0, reg_dst latched from the previous state; go to FETCH.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD; go to MEM_READ for op 23, MEM_WRITE for op 2b.
  - MEM_READ: mem_read=1, i_or_d=1; go to MEM_WB on mem_ready, else stay.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; go to FETCH.
  - MEM_WRITE: mem_write=1, i_or_d=1; go to FETCH on mem_ready, else stay.
  - BRANCH: alu_src_a=1, alu_src_b=00, pc_source=01. Go to FETCH.
    - op 4: alu_op=SUBEQ, pc_write_eq=1.
    - op 5: alu_op=SUBNE, pc_write_ne=1.
  - JUMP: pc_write=1, pc_source=10; go to FETCH.
  - TRAP: all strobes 0; stays in TRAP until reset.
- Opcode is sampled from op every cycle. The datapath holds IR stable after FETCH.
- Wait counter: counts cycles in FETCH, MEM_READ and MEM_WRITE while mem_ready==0.
  - Cleared on any state change.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: go to TRAP, bus_error<=1.
  - mem_ready==1 on the same cycle the count reaches MEM_TIMEOUT wins: normal transition, no error.
- Cycle counts with mem_ready always 1:
  - R/I-type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch/jump: 3 cycles.
- Reset mid-instruction: abandons it; no strobe is asserted in the reset cycle.

Optional Feature:
MULTICYCLE_JAL_EN.
- Defined:
  - Opcode 6'h3 in DECODE goes to state JAL: pc_write=1, pc_source=10, reg_write=1, plus new output link=1 (datapath writes PC into $31); then FETCH.
  - The link port exists (1 bit, 0 in all other states).
- Undefined: opcode 3 traps as illegal; the link port is absent.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode localparams: R_TYPE, ADDI, ORI, LUI, ANDI, BEQ, BNE, LW, SW, J, JAL.
  - ALU code constants.
  - state enum.
  - alu_src_b/pc_source encodings.
- One sub-module, mem_wait_timer: counter with a clear input, parametrised by MEM_TIMEOUT, output timeout.

Test Plan:
- Reset low 2 cycles, then high with mem_ready=1 and op=0: outputs all 0 during reset. FETCH then asserts mem_read=1, ir_write=1, pc_write=1. EXEC_R has alu_op=0. ALU_WB has reg_write=1, reg_dst=1. Back to FETCH after 4 cycles.
- op=23, mem_ready low for 3 cycles in MEM_READ: mem_read and i_or_d held 1 for 4 cycles; then MEM_WB with reg_write=1, mem_to_reg=1.
- op=5 (BNE): BRANCH asserts pc_write_ne=1, alu_op=6, pc_source=01; returns to FETCH on the next cycle.
- op=6'h3f: after DECODE enters TRAP, illegal_op=1, all strobes 0 for 20 cycles; reset clears it.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=15: bus_error=1 after 15 waiting cycles. A second run with mem_ready=1 on exactly cycle 15 gives no error.
- With MULTICYCLE_JAL_EN, op=3: JAL asserts pc_write=1, reg_write=1, link=1, pc_source=10. Without the macro, op=3 sets illegal_op=1.
